// File: rtl/id_stage.sv
// RV64I decode stage: IF/ID register, immediate/control decode,
// load-use hazard detection and a registered ID/EX boundary.
module id_stage #(
    parameter int          XLEN     = 64,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     if_inst,
    input  logic [XLEN-1:0] if_pc,
    input  logic            if_valid,
    input  logic            flush,
    input  logic            ex_memread,
    input  logic [4:0]      ex_rd,
    output logic            bubble,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_inst,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd,
    output logic [XLEN-1:0] id_imm,
    output logic            id_jal,
    output logic            id_jalr,
    output logic            id_branch,
    output logic            id_memread,
    output logic            id_memwrite,
    output logic            id_regwrite,
    output logic            id_illegal
);

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X
    } fmt_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            jal;
        logic            jalr;
        logic            branch;
        logic            memread;
        logic            memwrite;
        logic            regwrite;
        logic            illegal;
    } idex_t;

    logic            v_q, v_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;

    logic [6:0]      opcode;
    fmt_e            fmt;
    logic            dec_jal, dec_jalr, dec_branch;
    logic            dec_memread, dec_memwrite, dec_illegal;
    logic            uses_rs1, uses_rs2, writes_rd;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] imm;
    logic            hz;
    idex_t           idex_q, idex_d;

    // IF/ID register
    always_comb begin
        v_d    = v_q;
        pc_d   = pc_q;
        inst_d = inst_q;
        if (flush) begin
            v_d = 1'b0;
        end else if (!bubble) begin
            v_d    = if_valid;
            pc_d   = if_pc;
            inst_d = if_inst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= 1'b0;
            pc_q   <= '0;
            inst_q <= NOP_INST;
        end else begin
            v_q    <= v_d;
            pc_q   <= pc_d;
            inst_q <= inst_d;
        end
    end

    assign opcode = inst_q[6:0];

    always_comb begin
        fmt          = FMT_X;
        dec_jal      = 1'b0;
        dec_jalr     = 1'b0;
        dec_branch   = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        dec_illegal  = 1'b0;
        unique case (opcode)
            7'b0110111, 7'b0010111: fmt = FMT_U;
            7'b1101111: begin
                fmt     = FMT_J;
                dec_jal = 1'b1;
            end
            7'b1100111: begin
                fmt      = FMT_I;
                dec_jalr = 1'b1;
            end
            7'b1100011: begin
                fmt        = FMT_B;
                dec_branch = 1'b1;
            end
            7'b0000011: begin
                fmt         = FMT_I;
                dec_memread = 1'b1;
            end
            7'b0100011: begin
                fmt          = FMT_S;
                dec_memwrite = 1'b1;
            end
            7'b0010011, 7'b0011011, 7'b1110011: fmt = FMT_I;
            7'b0110011, 7'b0111011: fmt = FMT_R;
            default: dec_illegal = 1'b1;
        endcase
    end

    assign uses_rs1  = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
    assign uses_rs2  = fmt inside {FMT_R, FMT_S, FMT_B};
    assign writes_rd = fmt inside {FMT_R, FMT_I, FMT_U, FMT_J};

    assign rs1 = uses_rs1  ? inst_q[19:15] : 5'd0;
    assign rs2 = uses_rs2  ? inst_q[24:20] : 5'd0;
    assign rd  = writes_rd ? inst_q[11:7]  : 5'd0;

    always_comb begin
        imm = '0;
        unique case (fmt)
            FMT_I: imm = {{(XLEN-12){inst_q[31]}}, inst_q[31:20]};
            FMT_S: imm = {{(XLEN-12){inst_q[31]}},
                          inst_q[31:25], inst_q[11:7]};
            FMT_B: imm = {{(XLEN-13){inst_q[31]}}, inst_q[31],
                          inst_q[7], inst_q[30:25],
                          inst_q[11:8], 1'b0};
            FMT_U: imm = {{(XLEN-32){inst_q[31]}},
                          inst_q[31:12], 12'b0};
            FMT_J: imm = {{(XLEN-21){inst_q[31]}}, inst_q[31],
                          inst_q[19:12], inst_q[20],
                          inst_q[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    // Load-use: EX load writes a register this instruction reads
    assign hz = v_q & ex_memread & (ex_rd != 5'd0) &
                ((uses_rs1 & (rs1 == ex_rd)) |
                 (uses_rs2 & (rs2 == ex_rd)));
    assign bubble = hz & ~flush;

    always_comb begin
        idex_d      = '0;
        idex_d.inst = NOP_INST;
        idex_d.pc   = idex_q.pc;
        if (!(flush || bubble)) begin
            idex_d.valid    = v_q;
            idex_d.pc       = pc_q;
            idex_d.inst     = inst_q;
            idex_d.rs1      = rs1;
            idex_d.rs2      = rs2;
            idex_d.rd       = rd;
            idex_d.imm      = imm;
            idex_d.jal      = v_q & dec_jal;
            idex_d.jalr     = v_q & dec_jalr;
            idex_d.branch   = v_q & dec_branch;
            idex_d.memread  = v_q & dec_memread;
            idex_d.memwrite = v_q & dec_memwrite;
            idex_d.regwrite = v_q & writes_rd & (rd != 5'd0);
            idex_d.illegal  = v_q & dec_illegal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q      <= '0;
            idex_q.inst <= NOP_INST;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign id_valid    = idex_q.valid;
    assign id_pc       = idex_q.pc;
    assign id_inst     = idex_q.inst;
    assign id_rs1      = idex_q.rs1;
    assign id_rs2      = idex_q.rs2;
    assign id_rd       = idex_q.rd;
    assign id_imm      = idex_q.imm;
    assign id_jal      = idex_q.jal;
    assign id_jalr     = idex_q.jalr;
    assign id_branch   = idex_q.branch;
    assign id_memread  = idex_q.memread;
    assign id_memwrite = idex_q.memwrite;
    assign id_regwrite = idex_q.regwrite;
    assign id_illegal  = idex_q.illegal;

endmodule
